// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - sequential shift-add multiplier with register-file write-back
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   reset    in   asynchronous active-low reset
//   start    in   multiply request, sampled only while idle
//   op_a     in   WIDTH   multiplicand
//   op_b     in   WIDTH   multiplier
//   dest     in   ADDR_W  destination register address
//   sgn      in   1 = two's-complement operands, 0 = unsigned
//   hi_sel   in   1 = write upper half of product, 0 = lower half
//   busy     out  request accepted and not yet written back
//   wr_en    out  register-file write enable (one-cycle pulse)
//   wr_addr  out  ADDR_W  register-file write address
//   wr_data  out  WIDTH   register-file write data

module mul_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [ADDR_W-1:0] dest,
    input  logic              sgn,
    input  logic              hi_sel,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [4:0]         count;
    logic [ADDR_W-1:0]  dest_q;
    logic               neg_q;
    logic               hi_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;

    // Signed operands are reduced to magnitudes so the core is a plain
    // unsigned shift-add; the sign is reapplied to the full-width product.
    // The most negative value maps to itself, which is its correct magnitude.
    always_comb begin
        a_mag = op_a;
        b_mag = op_b;
        if (sgn && op_a[WIDTH-1]) a_mag = ~op_a + 1'b1;
        if (sgn && op_b[WIDTH-1]) b_mag = ~op_b + 1'b1;
    end

    assign prod = neg_q ? (~acc + 1'b1) : acc;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // After the last shift-add step the counter sits at 0 for one edge; that
    // edge negates/selects the product into the output registers, so the
    // write pulse occupies the WB cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == 5'd0) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= 5'd0;
            dest_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        count  <= 5'(WIDTH);
                        dest_q <= dest;
                        neg_q  <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        hi_q   <= hi_sel;
                    end
                end
                RUN: begin
                    if (count != 5'd0) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count - 5'd1;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= dest_q;
                        wr_data <= hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                    end
                end
                default: begin
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    wr_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - scoreboard testbench for mul_unit

module tb_mul_unit;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [ADDR_W-1:0] dest;
    logic              sgn;
    logic              hi_sel;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    mul_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .dest    (dest),
        .sgn     (sgn),
        .hi_sel  (hi_sel),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        int                wr_edge;
    } exp_t;

    exp_t              q[$];
    int                edge_cnt  = 0;
    int                busy_drop = -1;
    int                n_cmp     = 0;
    int                n_err     = 0;
    logic [WIDTH-1:0]  last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic s, input logic h);
        longint      pa;
        logic [63:0] p;
        if (s) pa = longint'($signed(a)) * longint'($signed(b));
        else   pa = longint'({48'd0, a}) * longint'({48'd0, b});
        p = pa;
        return h ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
    endfunction

    // Reference model: a request is taken only when the unit is idle at the
    // sampling edge; the write appears WIDTH+1 edges later and busy drops
    // WIDTH+2 edges later. Reset discards anything in flight.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (!reset) begin
                q.delete();
                busy_drop = -1;
            end else if (start && edge_cnt > busy_drop) begin
                e.addr    = dest;
                e.data    = ref_mul(op_a, op_b, sgn, hi_sel);
                e.wr_edge = edge_cnt + WIDTH + 1;
                q.push_back(e);
                busy_drop = edge_cnt + WIDTH + 2;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each cycle.
    initial begin
        exp_t e;
        logic exp_wr;
        forever begin
            @(posedge clk);
            #3;
            while (q.size() > 0 && q[0].wr_edge < edge_cnt) void'(q.pop_front());
            exp_wr = (q.size() > 0) && (q[0].wr_edge == edge_cnt);
            chk("busy", {31'd0, busy}, {31'd0, (edge_cnt < busy_drop)});
            chk("wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
            if (exp_wr) begin
                e = q.pop_front();
                chk("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
                chk("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                last_data = wr_data;
            end else begin
                chk("wr_addr_idle", {30'd0, wr_addr}, 32'd0);
                chk("wr_data_idle", {16'd0, wr_data}, 32'd0);
            end
        end
    end

    task automatic scramble();
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        dest   = 2'($urandom);
        sgn    = 1'($urandom);
        hi_sel = 1'($urandom);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [ADDR_W-1:0] d, input logic s, input logic h);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; dest = d; sgn = s; hi_sel = h;
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still 1 after 60 cycles");
        end
    endtask

    task automatic run_dir(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [ADDR_W-1:0] d, input logic s, input logic h,
                           input logic [WIDTH-1:0] exp_data);
        issue(a, b, d, s, h);
        wait_idle();
        chk(name, {16'd0, last_data}, {16'd0, exp_data});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        op_a = '0; op_b = '0; dest = '0; sgn = 1'b0; hi_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",    {31'd0, busy},   32'd0);
        chk("reset_wr_en",   {31'd0, wr_en},  32'd0);
        chk("reset_wr_addr", {30'd0, wr_addr}, 32'd0);
        chk("reset_wr_data", {16'd0, wr_data}, 32'd0);
        reset = 1'b1;

        run_dir("u_3x5",        16'd3,    16'd5,    2'd2, 1'b0, 1'b0, 16'h000F);
        run_dir("u_ffff_hi",    16'hFFFF, 16'hFFFF, 2'd1, 1'b0, 1'b1, 16'hFFFE);
        run_dir("u_ffff_lo",    16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 1'b0, 16'h0001);
        run_dir("s_m3x7_lo",    16'hFFFD, 16'h0007, 2'd0, 1'b1, 1'b0, 16'hFFEB);
        run_dir("s_m3x7_hi",    16'hFFFD, 16'h0007, 2'd1, 1'b1, 1'b1, 16'hFFFF);
        run_dir("s_8000_hi",    16'h8000, 16'h8000, 2'd2, 1'b1, 1'b1, 16'h4000);
        run_dir("zero_a",       16'h0000, 16'h1234, 2'd3, 1'b0, 1'b0, 16'h0000);
        run_dir("zero_b_s",     16'h8001, 16'h0000, 2'd1, 1'b1, 1'b1, 16'h0000);

        // Second request while busy must be ignored.
        issue(16'd6, 16'd7, 2'd1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; op_a = 16'd9; op_b = 16'd9; dest = 2'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("ignore_busy_start", {16'd0, last_data}, 32'h0000_002A);

        // Reset in the middle of RUN aborts with no write pulse.
        issue(16'd6, 16'd7, 2'd1, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, busy},  32'd0);
        chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        run_dir("after_abort_2x2", 16'd2, 16'd2, 2'd2, 1'b0, 1'b0, 16'h0004);

        // Start held high: requests accepted only when idle.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 90; i++) begin
            scramble();
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Randomized single requests.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 10 == 3) a = '0;
            if (i % 10 == 7) b = 16'h8000;
            issue(a, b, 2'($urandom), 1'($urandom), 1'($urandom));
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
